// File: rtl/combo_lock_ctrl_pkg.sv
// rtl/combo_lock_ctrl_pkg.sv - state encodings shared by the combination-lock sequencer
package combo_lock_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_LOCKED   = 3'd0,
      ST_CHECK    = 3'd1,
      ST_UNLOCKED = 3'd2,
      ST_PROG     = 3'd3,
      ST_ALARM    = 3'd4,
      ST_OCHECK   = 3'd5
   } state_e;

   // States in which keypad digits are collected into the entry buffer.
   function automatic logic is_entry_state(input state_e s);
      return (s == ST_LOCKED) || (s == ST_PROG) || (s == ST_ALARM);
   endfunction

endpackage

// File: rtl/combo_lock_ctrl_entry_buf.sv
// rtl/combo_lock_ctrl_entry_buf.sv - digit shift buffer with count and inter-digit timeout
module combo_lock_ctrl_entry_buf #(
   parameter int DIGIT_W     = 4,
   parameter int OVR_DIGITS  = 8,
   parameter int TIMEOUT_CYC = 100_000_000,
   localparam int BUF_W      = DIGIT_W * OVR_DIGITS,
   localparam int CNT_W      = $clog2(OVR_DIGITS + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               trigger_i,
   input  logic [DIGIT_W-1:0] digit_i,
   input  logic               accept_i,
   input  logic               clr_i,
   input  logic               timer_en_i,
   output logic [BUF_W-1:0]   data_o,
   output logic [CNT_W-1:0]   cnt_o,
   output logic               timeout_o
);

   localparam int TW = $clog2(TIMEOUT_CYC + 2);
   localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYC == 0) ? '0 : TW'(TIMEOUT_CYC - 1);

   logic [BUF_W-1:0] data_q;
   logic [CNT_W-1:0] cnt_q;
   logic [TW-1:0]    timer_q;
   logic             push;

   assign push = trigger_i && accept_i;

   // A digit arriving on the expiry cycle reloads the timer instead of timing out.
   assign timeout_o = (TIMEOUT_CYC != 0) && timer_en_i && (cnt_q != '0) && !push
                      && (timer_q == TO_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         cnt_q   <= '0;
         timer_q <= '0;
      end else if (clr_i || timeout_o) begin
         data_q  <= '0;
         cnt_q   <= '0;
         timer_q <= '0;
      end else if (push) begin
         data_q  <= {data_q[BUF_W-DIGIT_W-1:0], digit_i};
         cnt_q   <= cnt_q + CNT_W'(1);
         timer_q <= '0;
      end else if (timer_en_i && (cnt_q != '0)) begin
         timer_q <= timer_q + TW'(1);
      end else begin
         timer_q <= '0;
      end
   end

   assign data_o = data_q;
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/combo_lock_ctrl.sv
// rtl/combo_lock_ctrl.sv - keypad combination-lock sequencer with error count and override alarm
module combo_lock_ctrl
   import combo_lock_ctrl_pkg::*;
#(
   parameter int DIGIT_W     = 4,
   parameter int CODE_DIGITS = 4,
   parameter int OVR_DIGITS  = 8,
   parameter int MAX_ERR     = 3,
   parameter int ERR_W       = 2,
   parameter int TIMEOUT_CYC = 100_000_000,
   parameter logic [DIGIT_W*CODE_DIGITS-1:0] DEFAULT_CODE = 16'h0000,
   parameter logic [DIGIT_W*OVR_DIGITS-1:0]  OVR_CODE     = 32'h1234_5678,
   localparam int CNT_W = $clog2(OVR_DIGITS + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               trigger_i,
   input  logic [DIGIT_W-1:0] in_i,
   input  logic               clr_i,
   input  logic               lock_req_i,
   input  logic               prog_req_i,
   output logic [STATE_W-1:0] state_o,
   output logic               unlocked_o,
   output logic               alarm_o,
   output logic [ERR_W-1:0]   err_count_o,
   output logic [CNT_W-1:0]   digit_cnt_o
);

   localparam int CODE_W = DIGIT_W * CODE_DIGITS;
   localparam int BUF_W  = DIGIT_W * OVR_DIGITS;

   state_e            state_q;
   logic [CODE_W-1:0] usr_code_q;
   logic [ERR_W-1:0]  err_q;
   logic              unlocked_q;
   logic              alarm_q;

   logic [BUF_W-1:0]  buf_data;
   logic [CNT_W-1:0]  buf_cnt;
   logic              timeout;
   logic              entry_st, code_full, ovr_full, accept, abort, buf_clr;
   logic              code_match, ovr_match;
   logic [ERR_W-1:0]  err_inc;

   assign entry_st   = is_entry_state(state_q);
   assign code_full  = (buf_cnt == CNT_W'(CODE_DIGITS));
   assign ovr_full   = (buf_cnt == CNT_W'(OVR_DIGITS));
   assign accept     = entry_st && ((state_q == ST_ALARM) ? !ovr_full : !code_full);
   assign abort      = entry_st && (clr_i || timeout);
   assign code_match = (buf_data[CODE_W-1:0] == usr_code_q);
   assign ovr_match  = (buf_data == OVR_CODE);
   assign err_inc    = (err_q == ERR_W'(MAX_ERR)) ? err_q : err_q + ERR_W'(1);

   // Buffer is emptied on leaving either compare state, while unlocked, and once a new code is taken.
   assign buf_clr = (entry_st && clr_i) || (state_q == ST_CHECK) || (state_q == ST_OCHECK)
                    || (state_q == ST_UNLOCKED) || ((state_q == ST_PROG) && code_full);

   combo_lock_ctrl_entry_buf #(
      .DIGIT_W    (DIGIT_W),
      .OVR_DIGITS (OVR_DIGITS),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_entry_buf (
      .clk       (clk),
      .reset     (reset),
      .trigger_i (trigger_i),
      .digit_i   (in_i),
      .accept_i  (accept),
      .clr_i     (buf_clr),
      .timer_en_i(entry_st),
      .data_o    (buf_data),
      .cnt_o     (buf_cnt),
      .timeout_o (timeout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_LOCKED;
         usr_code_q <= DEFAULT_CODE;
         err_q      <= '0;
         unlocked_q <= 1'b0;
         alarm_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_LOCKED: if (!abort && code_full) state_q <= ST_CHECK;
            ST_CHECK: begin
               if (code_match) begin
                  state_q    <= ST_UNLOCKED;
                  err_q      <= '0;
                  unlocked_q <= 1'b1;
               end else begin
                  err_q <= err_inc;
                  if (err_inc == ERR_W'(MAX_ERR)) begin
                     state_q <= ST_ALARM;
                     alarm_q <= 1'b1;
                  end else begin
                     state_q <= ST_LOCKED;
                  end
               end
            end
            ST_UNLOCKED: begin
               if (lock_req_i || prog_req_i) begin
                  state_q    <= lock_req_i ? ST_LOCKED : ST_PROG;
                  unlocked_q <= 1'b0;
               end
            end
            ST_PROG: begin
               if (abort) begin
                  state_q    <= ST_UNLOCKED;
                  unlocked_q <= 1'b1;
               end else if (code_full) begin
                  usr_code_q <= buf_data[CODE_W-1:0];
                  state_q    <= ST_UNLOCKED;
                  unlocked_q <= 1'b1;
               end
            end
            ST_ALARM: if (!abort && ovr_full) state_q <= ST_OCHECK;
            ST_OCHECK: begin
               if (ovr_match) begin
                  state_q <= ST_LOCKED;
                  err_q   <= '0;
                  alarm_q <= 1'b0;
               end else begin
                  state_q <= ST_ALARM;
               end
            end
            default: begin
               state_q    <= ST_LOCKED;
               unlocked_q <= 1'b0;
               alarm_q    <= 1'b0;
            end
         endcase
      end
   end

   assign state_o     = state_q;
   assign unlocked_o  = unlocked_q;
   assign alarm_o     = alarm_q;
   assign err_count_o = err_q;
   assign digit_cnt_o = buf_cnt;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb/tb_combo_lock_ctrl.sv - directed and randomized bench against a queue-based lock model
module tb_combo_lock_ctrl;

   localparam int DIGIT_W     = 4;
   localparam int CODE_DIGITS = 4;
   localparam int OVR_DIGITS  = 8;
   localparam int MAX_ERR     = 3;
   localparam int ERR_W       = 2;
   localparam int TIMEOUT     = 16;
   localparam int CNT_W       = $clog2(OVR_DIGITS + 1);
   localparam longint OVR_CODE_L = 64'h1234_5678;

   logic clk = 1'b0;
   logic reset, trigger, clr, lock_req, prog_req;
   logic [DIGIT_W-1:0] din;
   logic [2:0]         state;
   logic               unlocked, alarm;
   logic [ERR_W-1:0]   err_count;
   logic [CNT_W-1:0]   digit_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: 0 LOCKED 1 CHECK 2 UNLOCKED 3 PROG 4 ALARM 5 OCHECK
   int     m_st, m_err, m_idle;
   int     q[$];
   longint m_code;

   always #5 clk = ~clk;

   combo_lock_ctrl #(
      .DIGIT_W(DIGIT_W), .CODE_DIGITS(CODE_DIGITS), .OVR_DIGITS(OVR_DIGITS),
      .MAX_ERR(MAX_ERR), .ERR_W(ERR_W), .TIMEOUT_CYC(TIMEOUT),
      .DEFAULT_CODE(16'h0000), .OVR_CODE(32'h1234_5678)
   ) dut (
      .clk(clk), .reset(reset), .trigger_i(trigger), .in_i(din), .clr_i(clr),
      .lock_req_i(lock_req), .prog_req_i(prog_req), .state_o(state), .unlocked_o(unlocked),
      .alarm_o(alarm), .err_count_o(err_count), .digit_cnt_o(digit_cnt)
   );

   function automatic longint q_val();
      longint v = 0;
      foreach (q[i]) v = v * (1 << DIGIT_W) + longint'(q[i]);
      return v;
   endfunction

   function automatic void model_reset();
      m_st = 0; m_err = 0; m_idle = 0; m_code = 0;
      q.delete();
   endfunction

   function automatic void model_step(input bit t, input int d, input bit c, input bit l, input bit p);
      int n     = q.size();
      bit entry = (m_st == 0) || (m_st == 3) || (m_st == 4);
      int lim   = (m_st == 4) ? OVR_DIGITS : CODE_DIGITS;
      bit take  = entry && t && (n < lim);
      bit to    = entry && (n > 0) && !take && (m_idle + 1 == TIMEOUT);
      bit abort = entry && (c || to);
      if (take && !abort) m_idle = 0;
      else if (entry && n > 0 && !abort) m_idle++;
      else m_idle = 0;
      if (abort) begin
         q.delete();
         if (m_st == 3) m_st = 2;
      end else begin
         case (m_st)
            0: if (n == CODE_DIGITS) m_st = 1; else if (take) q.push_back(d);
            1: begin
               if (q_val() == m_code) begin
                  m_st = 2; m_err = 0;
               end else begin
                  m_err = (m_err < MAX_ERR) ? m_err + 1 : MAX_ERR;
                  m_st  = (m_err == MAX_ERR) ? 4 : 0;
               end
               q.delete();
            end
            2: if (l) m_st = 0; else if (p) m_st = 3;
            3: if (n == CODE_DIGITS) begin
                  m_code = q_val(); q.delete(); m_st = 2;
               end else if (take) q.push_back(d);
            4: if (n == OVR_DIGITS) m_st = 5; else if (take) q.push_back(d);
            5: begin
               if (q_val() == OVR_CODE_L) begin m_st = 0; m_err = 0; end
               else m_st = 4;
               q.delete();
            end
            default: ;
         endcase
      end
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".state"}, state, m_st);
      chk({tag, ".unlocked"}, unlocked, (m_st == 2));
      chk({tag, ".alarm"}, alarm, (m_st == 4 || m_st == 5));
      chk({tag, ".err_count"}, err_count, m_err);
      chk({tag, ".digit_cnt"}, digit_cnt, q.size());
   endtask

   task automatic step(input bit t, input int d, input bit c, input bit l, input bit p);
      trigger = t; din = DIGIT_W'(d); clr = c; lock_req = l; prog_req = p;
      @(posedge clk);
      model_step(t, d, c, l, p);
      #1;
      trigger = 0; clr = 0; lock_req = 0; prog_req = 0;
      check_all("cycle");
   endtask

   task automatic key(input int d);
      step(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic enter(input longint code, input int n);
      for (int i = n - 1; i >= 0; i--) key(int'((code >> (DIGIT_W * i)) & 64'hF));
      idle(2);
   endtask

   initial begin
      int r;
      trigger = 0; din = '0; clr = 0; lock_req = 0; prog_req = 0; reset = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      chk("reset_state", state, 0);
      chk("reset_unlocked", unlocked, 0);
      reset = 0;

      // default code unlocks after a one-cycle CHECK
      repeat (4) key(0);
      chk("t1_cnt4", digit_cnt, 4);
      idle(1);
      chk("t1_check", state, 1);
      idle(1);
      chk("t1_unlocked", unlocked, 1);
      chk("t1_err0", err_count, 0);
      step(0, 0, 0, 1, 0);

      // three failures lead to alarm
      enter(64'h1234, 4);
      chk("t2_err1", err_count, 1);
      enter(64'h1234, 4);
      chk("t2_err2", err_count, 2);
      enter(64'h1234, 4);
      chk("t2_alarm", alarm, 1);
      chk("t2_state4", state, 4);

      // override clears alarm; wrong override keeps it
      enter(OVR_CODE_L, 8);
      chk("t3_locked", state, 0);
      chk("t3_err0", err_count, 0);
      repeat (3) enter(64'h1234, 4);
      enter(64'h1234_5679, 8);
      chk("t3_still_alarm", state, 4);
      chk("t3_cnt0", digit_cnt, 0);
      enter(OVR_CODE_L, 8);

      // reprogram and use the new code
      enter(64'h0000, 4);
      step(0, 0, 0, 0, 1);
      chk("t4_prog", state, 3);
      enter(64'hABCD, 4);
      chk("t4_prog_done", state, 2);
      step(0, 0, 0, 1, 0);
      enter(64'hABCD, 4);
      chk("t4_new_code", unlocked, 1);
      step(0, 0, 0, 1, 0);
      enter(64'h0000, 4);
      chk("t4_old_code_err", err_count, 1);

      // inter-digit timeout and clr priority
      key(1); key(2);
      idle(TIMEOUT - 1);
      chk("t5_pre_timeout", digit_cnt, 2);
      idle(1);
      chk("t5_timeout", digit_cnt, 0);
      chk("t5_err_kept", err_count, 1);
      key(3);
      step(1, 4, 1, 0, 0);
      chk("t5_clr_wins", digit_cnt, 0);

      // reset during programming restores the default code
      enter(64'hABCD, 4);
      step(0, 0, 0, 0, 1);
      key(1); key(2);
      chk("t6_prog_cnt", digit_cnt, 2);
      reset = 1;
      #1;
      model_reset();
      check_all("async_reset");
      chk("t6_reset_state", state, 0);
      @(posedge clk);
      #1;
      reset = 0;
      enter(64'h0000, 4);
      chk("t6_default_code", unlocked, 1);
      step(0, 0, 0, 1, 1);
      chk("t6_lock_wins", state, 0);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         r = int'($urandom_range(0, 99));
         if (m_st == 4 && q.size() == 0 && r < 15) enter(OVR_CODE_L, 8);
         else if (r < 45) key(int'($urandom_range(0, 2)));
         else if (r < 48) step(0, 0, 1, 0, 0);
         else if (r < 50) step(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1, 0, 0);
         else if (r < 56) step(0, 0, 0, 1, 0);
         else if (r < 62) step(0, 0, 0, 0, 1);
         else if (r < 64) step(0, 0, 0, 1, 1);
         else if (r < 67) idle(int'($urandom_range(12, 20)));
         else idle(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
